// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT datapath constants plus complex-slice and saturation helpers.
package fft_pkg;
    localparam int DATA_W  = 16;
    localparam int TF_FRAC = 15;
    localparam int CW      = 2 * DATA_W;

    function automatic logic signed [DATA_W-1:0] re(input logic [CW-1:0] c);
        return c[CW-1:DATA_W];
    endfunction

    function automatic logic signed [DATA_W-1:0] im(input logic [CW-1:0] c);
        return c[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [CW:0] x);
        return (x > 33'sd32767) ? 16'sh7FFF : (x < -33'sd32768) ? 16'sh8000 : x[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/cmul_conj_q15.sv
// cmul_conj_q15: two-stage multiply by the conjugate of a Q1.15 twiddle,
// floor-truncated and saturated back to DATA_W per component.
module cmul_conj_q15
    import fft_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          en_i,
    input  logic [CW-1:0] d_i,
    input  logic [CW-1:0] tf_i,
    output logic [CW-1:0] b_o
);
    logic signed [CW-1:0] pr1_q, pr2_q, pj1_q, pj2_q;
    logic signed [CW:0]   br, bj;
    logic [CW-1:0]        b_d, b_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pr1_q <= '0;
            pr2_q <= '0;
            pj1_q <= '0;
            pj2_q <= '0;
            b_q   <= '0;
        end else if (en_i) begin
            pr1_q <= CW'(re(d_i)) * CW'(re(tf_i));
            pr2_q <= CW'(im(d_i)) * CW'(im(tf_i));
            pj1_q <= CW'(im(d_i)) * CW'(re(tf_i));
            pj2_q <= CW'(re(d_i)) * CW'(im(tf_i));
            b_q   <= b_d;
        end
    end

    // conj(tf) flips the sign of the imaginary cross terms
    always_comb begin
        br  = (CW+1)'(pr1_q) + (CW+1)'(pr2_q);
        bj  = (CW+1)'(pj1_q) - (CW+1)'(pj2_q);
        b_d = {sat16(br >>> TF_FRAC), sat16(bj >>> TF_FRAC)};
    end

    assign b_o = b_q;
endmodule

// File: rtl/ibutterflyx8.sv
// ibutterflyx8: inverse radix-2 butterfly, a = (y+z)/2, b = ((y-z)/2)*conj(tf),
// three-stage pipeline with a global stall on output back-pressure.
module ibutterflyx8
    import fft_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] y,
    input  logic [CW-1:0] z,
    input  logic [CW-1:0] tf,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] a,
    output logic [CW-1:0] b
);
    logic                   advance;
    logic                   v1_q, v2_q, v3_q;
    logic [CW-1:0]          a1_d, d1_d, a1_q, d1_q, tf1_q, a2_q, a3_q;
    logic signed [DATA_W:0] s_r, s_j, dd_r, dd_j;

    assign advance   = !v3_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = v3_q;
    assign a         = a3_q;

    // 17-bit sum/difference halved with floor always fits DATA_W, so sat16 never clips here
    always_comb begin
        s_r  = (DATA_W+1)'(re(y)) + (DATA_W+1)'(re(z));
        s_j  = (DATA_W+1)'(im(y)) + (DATA_W+1)'(im(z));
        dd_r = (DATA_W+1)'(re(y)) - (DATA_W+1)'(re(z));
        dd_j = (DATA_W+1)'(im(y)) - (DATA_W+1)'(im(z));
        a1_d = {sat16((CW+1)'(s_r >>> 1)), sat16((CW+1)'(s_j >>> 1))};
        d1_d = {sat16((CW+1)'(dd_r >>> 1)), sat16((CW+1)'(dd_j >>> 1))};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            a1_q  <= '0;
            d1_q  <= '0;
            tf1_q <= '0;
            a2_q  <= '0;
            a3_q  <= '0;
        end else if (advance) begin
            v1_q  <= in_valid;
            a1_q  <= a1_d;
            d1_q  <= d1_d;
            tf1_q <= tf;
            v2_q  <= v1_q;
            a2_q  <= a1_q;
            v3_q  <= v2_q;
            a3_q  <= a2_q;
        end
    end

    cmul_conj_q15 u_cmul (
        .clock (clock),
        .reset (reset),
        .en_i  (advance),
        .d_i   (d1_q),
        .tf_i  (tf1_q),
        .b_o   (b)
    );
endmodule

// File: tb/tb_ibutterflyx8.sv
// tb_ibutterflyx8: directed checks of ibutterflyx8 plus a forward/inverse round trip.
module tb_ibutterflyx8;
    logic        clock, reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] y, z, tf, a, b;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] qy[$], qz[$], qt[$], qa[$], qb[$];

    ibutterflyx8 dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .z         (z),
        .tf        (tf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit near(input logic [31:0] g, input logic [31:0] e, input int tol);
        int dr, dj;
        dr = int'($signed(g[31:16])) - int'($signed(e[31:16]));
        dj = int'($signed(g[15:0])) - int'($signed(e[15:0]));
        return !$isunknown(g) && dr <= tol && dr >= -tol && dj <= tol && dj >= -tol;
    endfunction

    task automatic chk_near(input string tag, input logic [31:0] got, input logic [31:0] exp, input int tol);
        checks++;
        assert (near(got, exp, tol)) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h tol=%0d", tag, got, exp, tol);
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] vy, vz, vt, ea, eb);
        @(negedge clock);
        in_valid = 1; y = vy; z = vz; tf = vt; out_ready = 1;
        @(negedge clock);
        in_valid = 0;
        @(negedge clock);
        chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        @(negedge clock);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_a"}, a, ea);
        chk({tag, "_b"}, b, eb);
    endtask

    task automatic push(input logic [31:0] vy, vz, vt, ea, eb);
        qy.push_back(vy); qz.push_back(vz); qt.push_back(vt); qa.push_back(ea); qb.push_back(eb);
    endtask

    task automatic stream(input string tag, input bit stall_win, input int tol);
        int n, sent, got;
        bit hold;
        logic [31:0] ha, hb;
        n = qy.size(); sent = 0; got = 0; hold = 0; ha = '0; hb = '0;
        for (int c = 0; c < n + 40 && got < n; c++) begin
            @(negedge clock);
            out_ready = !(stall_win && c >= 3 && c <= 6);
            in_valid  = sent < n;
            if (sent < n) begin
                y = qy[sent]; z = qz[sent]; tf = qt[sent];
            end
            #1;
            if (hold) begin
                chk({tag, "_hold_a"}, a, ha);
                chk({tag, "_hold_b"}, b, hb);
            end
            hold = out_valid && !out_ready;
            if (hold) begin
                chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
                ha = a; hb = b;
            end
            if (out_valid && out_ready) begin
                chk_near({tag, "_a"}, a, qa[got], tol);
                chk_near({tag, "_b"}, b, qb[got], tol);
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 0; out_ready = 1;
        chk({tag, "_count"}, 32'(got), 32'(n));
        repeat (4) @(negedge clock);
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
        qy.delete(); qz.delete(); qt.delete(); qa.delete(); qb.delete();
    endtask

    initial begin
        clock = 0; reset = 1; in_valid = 0; out_ready = 1; y = '0; z = '0; tf = '0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_a", a, 32'd0);
        chk("rst_b", b, 32'd0);
        reset = 0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        run_one("c1_tf_one", 32'h0100_0080, 32'h0080_0040, 32'h7FFF_0000, 32'h00C0_0060, 32'h003F_001F);
        run_one("c2_tf_mj", 32'h03E8_0000, 32'h0000_0000, 32'h0000_8000, 32'h01F4_0000, 32'h0000_01F4);
        run_one("c3_sat", 32'h8000_8000, 32'h7FFF_7FFF, 32'h8000_8000, 32'hFFFF_FFFF, 32'h7FFF_0000);
        run_one("c4_floor", 32'h0003_FFFD, 32'h0000_0000, 32'h7FFF_0000, 32'h0001_FFFE, 32'h0000_FFFE);

        push(32'h0100_0080, 32'h0080_0040, 32'h7FFF_0000, 32'h00C0_0060, 32'h003F_001F);
        push(32'h03E8_0000, 32'h0000_0000, 32'h0000_8000, 32'h01F4_0000, 32'h0000_01F4);
        push(32'h8000_8000, 32'h7FFF_7FFF, 32'h8000_8000, 32'hFFFF_FFFF, 32'h7FFF_0000);
        push(32'h0003_FFFD, 32'h0000_0000, 32'h7FFF_0000, 32'h0001_FFFE, 32'h0000_FFFE);
        push(32'h0010_0020, 32'h0002_0004, 32'h0000_8000, 32'h0009_0012, 32'hFFF2_0007);
        stream("c5_bp", 1'b1, 0);

        @(negedge clock);
        out_ready = 0; in_valid = 1;
        y = 32'h03E8_0000; z = 32'h0; tf = 32'h0000_8000;
        repeat (4) @(negedge clock);
        chk("c6_pre_valid", 32'(out_valid), 32'd1);
        chk("c6_pre_in_ready", 32'(in_ready), 32'd0);
        #2 reset = 1;
        #1;
        chk("c6_rst_valid", 32'(out_valid), 32'd0);
        chk("c6_rst_a", a, 32'd0);
        chk("c6_rst_b", b, 32'd0);
        @(negedge clock);
        reset = 0; in_valid = 0; out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("c6_no_stale", 32'(out_valid), 32'd0);
        end

        // forward butterfly y = a + b*tf, z = a - b*tf with twiddles that multiply exactly
        for (int i = 0; i < 1000; i++) begin
            int ar, aj, br, bj, fr, fi, tr, ti;
            ar = int'($urandom_range(32766)) - 16383;
            aj = int'($urandom_range(32766)) - 16383;
            br = int'($urandom_range(32766)) - 16383;
            bj = int'($urandom_range(32766)) - 16383;
            if ($urandom_range(1) == 1) begin fr = -32768; fi = 0; end
            else begin fr = 0; fi = -32768; end
            tr = int'((longint'(br) * fr - longint'(bj) * fi) >>> 15);
            ti = int'((longint'(br) * fi + longint'(bj) * fr) >>> 15);
            push({16'(ar + tr), 16'(aj + ti)}, {16'(ar - tr), 16'(aj - ti)},
                 {16'(fr), 16'(fi)}, {16'(ar), 16'(aj)}, {16'(br), 16'(bj)});
        end
        stream("rt", 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
